// File: rtl/cdf_store_sequencer.sv
// CDF store-phase sequencer: packs LANES 20-bit CDF results per memory word and
// issues consecutive SRAM writes from a latched base until all bins are stored.
module cdf_store_sequencer #(
  parameter int NUM_BINS = 256,
  parameter int LANES    = 4,
  parameter int LANE_W   = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    Start,
  input  logic [15:0]             BaseAddress,
  input  logic                    ResultValid,
  input  logic [19:0]             ResultIn,
  output logic                    ResultReady,
  output logic [LANES*LANE_W-1:0] WriteBus,
  output logic [15:0]             WriteAddress,
  output logic                    WriteEnable,
  input  logic                    WriteAccept,
  output logic                    Busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  // Handshakes: a result transfers on a clock edge where ResultValid && ResultReady;
  // a write transfers on an edge where WriteEnable && WriteAccept, and the write
  // request (enable, data, address) is held stable until that edge.
  localparam int WORDS = NUM_BINS / LANES;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BUS_W = LANES * LANE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [BUS_W-1:0]   lanes_q, lanes_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [15:0]        base_q, base_d;
  logic [BUS_W-1:0]   wbus_q, wbus_d;
  logic [15:0]        waddr_q, waddr_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic hs, accept, last_lane, last_word;

  assign hs        = ResultValid && (state_q == COLLECT);
  assign accept    = we_q && WriteAccept;
  assign last_lane = (idx_q == IDX_W'(LANES - 1));
  assign last_word = (wc_q == WC_W'(WORDS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lanes_q <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      base_q  <= '0;
      wbus_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      base_q  <= base_d;
      wbus_q  <= wbus_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = COLLECT;
      COLLECT: if (hs && last_lane) state_d = WRITE;
      WRITE:   if (accept) state_d = last_word ? IDLE : COLLECT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    base_d  = base_q;
    wbus_d  = wbus_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          base_d = BaseAddress;
          idx_d  = '0;
          wc_d   = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      COLLECT: begin
        if (hs) begin
          lanes_d[int'(idx_q)*LANE_W +: LANE_W] = LANE_W'(ResultIn);
          if (last_lane) begin
            // The packed word includes the lane being written this cycle.
            wbus_d  = lanes_d;
            waddr_d = base_q + 16'(wc_q);
            we_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          we_d = 1'b0;
          if (last_word) begin
            wbus_d  = '0;
            waddr_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wc_d  = wc_q + 1'b1;
            idx_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign ResultReady  = (state_q == COLLECT);
  assign WriteBus     = wbus_q;
  assign WriteAddress = waddr_q;
  assign WriteEnable  = we_q;
  assign Busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cdf_store_sequencer.sv
// Bench for cdf_store_sequencer: three instances (256, 4 and 8 bins) share the
// stimulus; a write monitor pops {address, data} from an expected queue.
module tb_cdf_store_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, start, valid, acc;
  logic [15:0] base;
  logic [19:0] din;
  int          sel;

  logic         start_g [3];
  logic         rdy     [3];
  logic [127:0] wbus    [3];
  logic [15:0]  waddr   [3];
  logic         we      [3];
  logic         busy    [3];
  logic         done    [3];
  logic [1:0]   dbg     [3];

  logic         m_rdy, m_we, m_busy, m_done;
  logic [127:0] m_wbus;
  logic [15:0]  m_waddr;
  logic [1:0]   m_dbg;

  logic [19:0]  res_q[$];
  logic [143:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 256 : ((g == 1) ? 4 : 8);
    assign start_g[g] = start && (sel == g);
    cdf_store_sequencer #(.NUM_BINS(NB)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .Start        (start_g[g]),
      .BaseAddress  (base),
      .ResultValid  (valid),
      .ResultIn     (din),
      .ResultReady  (rdy[g]),
      .WriteBus     (wbus[g]),
      .WriteAddress (waddr[g]),
      .WriteEnable  (we[g]),
      .WriteAccept  (acc),
      .Busy         (busy[g]),
      .done         (done[g]),
      .dbg_state    (dbg[g])
    );
  end

  always_comb begin
    m_rdy   = rdy[sel];
    m_wbus  = wbus[sel];
    m_waddr = waddr[sel];
    m_we    = we[sel];
    m_busy  = busy[sel];
    m_done  = done[sel];
    m_dbg   = dbg[sel];
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: a write transfers on the edge following a negedge with we && acc.
  always @(negedge clock) begin
    if (reset_n && m_we && acc) begin
      logic [143:0] e;
      wr_count++;
      check("exp_avail", 144'(exp_q.size() != 0), 144'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 144'(m_waddr), 144'(e[143:128]));
        check("wr_data", 144'(m_wbus), 144'(e[127:0]));
      end
    end
  end

  task automatic gen_word(input logic [15:0] addr, input bit seq, input int seq_base,
                          output logic [127:0] w);
    logic [19:0] v;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      v = seq ? 20'(seq_base + i) : 20'($urandom_range(0, 20'hFFFFF));
      res_q.push_back(v);
      w[32*i +: 32] = {12'h000, v};
    end
    exp_q.push_back({addr, w});
  endtask

  task automatic start_pass(input logic [15:0] b);
    @(posedge clock); #1;
    start = 1'b1;
    base  = b;
    @(posedge clock); #1;
    start = 1'b0;
    base  = 16'hABCD;
  endtask

  task automatic feed(input int n, input bit toggle);
    int sent = 0;
    int cyc  = 0;
    bit ph   = 1'b0;
    while (sent < n && cyc < 4000) begin
      @(posedge clock); #1;
      ph    = toggle ? ~ph : 1'b1;
      valid = ph;
      din   = (res_q.size() != 0) ? res_q[0] : 20'h0;
      @(negedge clock);
      if (valid && m_rdy) begin
        void'(res_q.pop_front());
        sent++;
      end
      cyc++;
    end
    if (sent < n) check("feed_timeout", 144'(sent), 144'(n));
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    @(negedge clock);
    while (!m_done && c < limit) begin
      @(negedge clock);
      c++;
    end
    check("done_rise", 144'(m_done), 144'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    int wr0;
    reset_n = 1'b0; start = 1'b0; valid = 1'b0; acc = 1'b0;
    base = '0; din = '0; sel = 0;

    // Reset and idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_done", 144'(m_done), 144'd1);
    check("rst_busy", 144'(m_busy), 144'd0);
    check("rst_we", 144'(m_we), 144'd0);
    check("rst_wbus", 144'(m_wbus), 144'd0);
    check("rst_rdy", 144'(m_rdy), 144'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("idle_done", 144'(m_done), 144'd1);
    check("idle_busy", 144'(m_busy), 144'd0);
    check("idle_we", 144'(m_we), 144'd0);
    check("idle_rdy", 144'(m_rdy), 144'd0);

    // Single word packing, Start held across the final accept
    sel = 1; acc = 1'b1; wr0 = wr_count;
    res_q.push_back(20'h00001); res_q.push_back(20'h00002);
    res_q.push_back(20'h00003); res_q.push_back(20'hFFFFF);
    exp_q.push_back({16'h0100, 128'h000FFFFF_00000003_00000002_00000001});
    start_pass(16'h0100);
    @(negedge clock);
    check("start_busy", 144'(m_busy), 144'd1);
    check("start_done", 144'(m_done), 144'd0);
    feed(4, 1'b0);
    start = 1'b1;
    @(negedge clock);
    check("wr_latency_we", 144'(m_we), 144'd1);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("sw_done", 144'(m_done), 144'd1);
    check("sw_busy", 144'(m_busy), 144'd0);
    check("sw_we_off", 144'(m_we), 144'd0);
    check("sw_wbus_clr", 144'(m_wbus), 144'd0);
    check("sw_waddr_clr", 144'(m_waddr), 144'd0);
    @(negedge clock);
    check("sw_no_restart", 144'(m_dbg), 144'd0);
    check("sw_writes", 144'(wr_count - wr0), 144'd1);

    // Backpressure
    acc = 1'b0; wr0 = wr_count;
    gen_word(16'h0300, 1'b0, 0, w);
    start_pass(16'h0300);
    feed(4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_we", 144'(m_we), 144'd1);
      check("bp_addr", 144'(m_waddr), 144'h0300);
      check("bp_data", 144'(m_wbus), 144'(w));
      check("bp_rdy", 144'(m_rdy), 144'd0);
    end
    @(posedge clock); #1;
    acc = 1'b1;
    @(posedge clock); #1;
    acc = 1'b0;
    wait_done(20);
    check("bp_writes", 144'(wr_count - wr0), 144'd1);

    // Full default pass, sequential data, valid every other cycle
    sel = 0; acc = 1'b1; wr0 = wr_count;
    for (int k = 0; k < 64; k++) gen_word(16'(16'h2000 + k), 1'b1, 4 * k, w);
    start_pass(16'h2000);
    feed(256, 1'b1);
    wait_done(50);
    check("full_writes", 144'(wr_count - wr0), 144'd64);
    check("full_drained", 144'(exp_q.size()), 144'd0);

    // Address wrap with an ignored mid-pass Start
    sel = 2; wr0 = wr_count;
    gen_word(16'hFFFF, 1'b0, 0, w);
    gen_word(16'h0000, 1'b0, 0, w);
    start_pass(16'hFFFF);
    feed(2, 1'b0);
    @(posedge clock); #1;
    start = 1'b1; base = 16'h1234;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("wrap_busy", 144'(m_busy), 144'd1);
    check("wrap_state", 144'(m_dbg), 144'd1);
    feed(6, 1'b0);
    wait_done(50);
    check("wrap_writes", 144'(wr_count - wr0), 144'd2);
    check("wrap_drained", 144'(exp_q.size()), 144'd0);

    // Reset mid-pass, then a fresh pass from base 0
    sel = 0; wr0 = wr_count;
    for (int k = 0; k < 3; k++) gen_word(16'(16'h1000 + k), 1'b0, 0, w);
    res_q.push_back(20'hAAAAA); res_q.push_back(20'h55555);
    start_pass(16'h1000);
    feed(14, 1'b0);
    check("mid_pre_writes", 144'(wr_count - wr0), 144'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", 144'(m_we), 144'd0);
    check("mid_rst_rdy", 144'(m_rdy), 144'd0);
    check("mid_rst_busy", 144'(m_busy), 144'd0);
    check("mid_rst_done", 144'(m_done), 144'd1);
    res_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    wr0 = wr_count;
    for (int k = 0; k < 64; k++) gen_word(16'(k), 1'b0, 0, w);
    start_pass(16'h0000);
    feed(256, 1'b0);
    wait_done(50);
    check("fresh_writes", 144'(wr_count - wr0), 144'd64);
    check("fresh_drained", 144'(exp_q.size()), 144'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdf_store_sequencer.md
Name: cdf_store_sequencer

Overview:
Sequences the CDF store phase of the histogram-equalization pipeline. It accepts 20-bit CDF results one per handshake and packs four results into each 128-bit memory word. It generates consecutive write addresses from a programmable base and drives the shared SRAM write port, holding each word until the port accepts it. It reports completion once all bins are written.

Parameters:
NUM_BINS, 256, number of CDF results per store pass; must be a multiple of LANES
LANES, 4, results packed per 128-bit write word
LANE_W, 32, bit width of each lane in WriteBus; each result is zero-extended from 20 bits to this width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Start  input  1  begins a store pass; sampled only in IDLE
BaseAddress  input  16  first word address; latched on an accepted Start
ResultValid  input  1  ResultIn carries a valid CDF value
ResultIn  input  20  CDF value for the next bin, in ascending bin order
ResultReady  output  1  block can accept ResultIn this cycle
WriteBus  output  128  packed write data
WriteAddress  output  16  word address for the write
WriteEnable  output  1  write request; held until accepted
WriteAccept  input  1  memory port accepts the write this cycle
Busy  output  1  a store pass is in progress
done  output  1  high when idle and no pass is in progress

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: state=IDLE, WriteBus=0, WriteAddress=0, WriteEnable=0, ResultReady=0, Busy=0, done=1. All lane registers, the lane index, the word counter and the latched base are cleared.
- States are IDLE, COLLECT and WRITE. All outputs are registered except ResultReady, which is decoded as (state==COLLECT).
- IDLE:
  - done=1, Busy=0.
  - On Start=1: latch BaseAddress, clear lane index and word counter, go to COLLECT. Next cycle Busy=1, done=0.
- COLLECT:
  - A handshake occurs when ResultValid && ResultReady.
  - On a handshake, ResultIn zero-extended is written into lane[idx] at bits [LANE_W*idx+LANE_W-1 : LANE_W*idx]; lane 0 occupies bits [31:0].
  - When idx==LANES-1 at the handshake: go to WRITE. Next cycle WriteEnable=1, WriteBus=packed lanes and WriteAddress=base+wordcount.
  - Otherwise idx increments.
  - ResultValid=0 causes no state change.
- WRITE:
  - ResultReady=0. WriteEnable, WriteBus and WriteAddress stay stable until WriteAccept=1.
  - On accept with wordcount==NUM_BINS/LANES-1: go to IDLE. Next cycle WriteEnable=0, WriteBus=0, WriteAddress=0, Busy=0, done=1.
  - On accept otherwise: wordcount increments, idx clears, go to COLLECT. WriteEnable drops the next cycle.
  - WriteAccept while WriteEnable=0 is ignored.
- Latency:
  - Final result handshake at cycle N gives WriteEnable=1 at N+1.
  - With WriteAccept tied high, each word costs LANES+1 cycles.
  - A full default pass takes 64 writes and 320 cycles from Start to done.
- Address arithmetic is 16-bit modulo: base 0xFFFF followed by a second word wraps to 0x0000.
- Start while Busy is ignored and does not restart or relatch the base.
- Start asserted in the same cycle as the final accept is ignored. A new pass needs Start in IDLE.
- Reset mid-pass aborts immediately. All partial lanes are discarded and no write is issued after reset.
- Lane contents are not cleared between words. Every word is fully overwritten before it is written.

Test Plan:
- Reset then idle: hold reset_n=0 → done=1, Busy=0, WriteEnable=0, WriteBus=0, ResultReady=0. Release with Start=0 for 10 cycles → outputs unchanged.
- Single word packing (NUM_BINS=4): BaseAddress=0x0100, Start, feed ResultIn 0x00001, 0x00002, 0x00003, 0xFFFFF with WriteAccept=1 → one write, WriteAddress=0x0100, WriteBus=0x000FFFFF_00000003_00000002_00000001, then done=1.
- Backpressure: hold WriteAccept=0 for 5 cycles during WRITE → WriteEnable/WriteBus/WriteAddress constant and ResultReady=0. Accept on cycle 6 → exactly one write counted.
- Full pass (default): base 0x2000, results 0..255 with ResultValid toggling every other cycle → 64 writes at addresses 0x2000..0x203F, word k lanes hold 4k..4k+3, done rises after the final accept.
- Wrap and ignored Start (NUM_BINS=8): base 0xFFFF, pulse Start during COLLECT → addresses 0xFFFF then 0x0000, base not relatched.
- Reset mid-pass: assert reset_n=0 after 2 results of word 3 → WriteEnable=0 at once. New pass from base 0x0000 writes only fresh data starting at 0x0000.
